// File: rtl/mux_hot_stream.sv
`default_nettype none
// ============================================================================
// Module   : mux_hot_stream
// Brief    : One-hot selected valid/ready stream mux with a 2-entry skid
//            buffer, source tagging and a saturating illegal-select counter.
// Revision : 1.0 - initial release
// ============================================================================
module mux_hot_stream #(
    parameter  int INPUTS    = 2,
    parameter  int WIDTH     = 32,
    parameter  int ERR_CNT_W = 8,
    localparam int SRC_W     = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data [INPUTS],
    input  logic [INPUTS-1:0]    in_valid,
    output logic [INPUTS-1:0]    in_ready,
    input  logic [INPUTS-1:0]    sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SRC_W-1:0]     out_src,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err_sel,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    logic                 w_nonzero;
    logic                 w_multi;
    logic                 w_legal;
    logic                 w_illegal;
    logic                 w_accept;
    logic                 w_drain;
    logic [SRC_W-1:0]     w_idx;
    logic [WIDTH-1:0]     w_beat;

    logic [WIDTH-1:0]     r_out_data;
    logic [SRC_W-1:0]     r_out_src;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_skid_data;
    logic [SRC_W-1:0]     r_skid_src;
    logic                 r_skid_full;
    logic                 r_err_sel;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign w_nonzero = |sel;
    assign w_multi   = |(sel & (sel - INPUTS'(1)));
    assign w_legal   = w_nonzero & ~w_multi;
    assign w_illegal = w_multi;

    always_comb begin
        w_idx  = '0;
        w_beat = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (sel[i]) begin
                w_idx  = SRC_W'(i);
                w_beat = in_data[i];
            end
        end
    end

    assign in_ready = (w_legal && !r_skid_full && rst_n) ? sel : '0;
    assign w_accept = |(in_valid & in_ready);
    assign w_drain  = ~r_out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_out_valid <= 1'b0;
            r_skid_data <= '0;
            r_skid_src  <= '0;
            r_skid_full <= 1'b0;
        end else if (w_drain && r_skid_full) begin
            r_out_data  <= r_skid_data;
            r_out_src   <= r_skid_src;
            r_out_valid <= 1'b1;
            r_skid_full <= 1'b0;
        end else if (w_drain) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_data <= w_beat;
                r_out_src  <= w_idx;
            end
        end else if (w_accept) begin
            r_skid_data <= w_beat;
            r_skid_src  <= w_idx;
            r_skid_full <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sel <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err_sel <= w_illegal;
            if (err_clr) begin
                r_err_cnt <= '0;
            end else if (w_illegal && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_valid = r_out_valid;
    assign err_sel   = r_err_sel;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mux_hot_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_hot_stream
// Brief    : Self-checking bench for mux_hot_stream (4 inputs, 2-bit counter).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_hot_stream;

    localparam int INPUTS = 4;
    localparam int WIDTH  = 16;
    localparam int ERRW   = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] in_data [INPUTS];
    logic [3:0]       in_valid = '0;
    logic [3:0]       in_ready;
    logic [3:0]       sel = '0;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_src;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             err_sel;
    logic [ERRW-1:0]  err_cnt;
    logic             err_clr = 1'b0;

    mux_hot_stream #(.INPUTS(INPUTS), .WIDTH(WIDTH), .ERR_CNT_W(ERRW)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .out_data(out_data), .out_src(out_src),
        .out_valid(out_valid), .out_ready(out_ready), .err_sel(err_sel),
        .err_cnt(err_cnt), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Reference model: the buffered beats as a FIFO of at most two entries.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [1:0]       src;
    } beat_t;

    beat_t            q[$];
    logic [WIDTH-1:0] m_last_data = '0;
    logic [1:0]       m_last_src  = '0;
    logic             m_esel = 1'b0;
    int               m_ecnt = 0;
    logic [3:0]       rdy_before;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]       s;
        logic [3:0]       v;
        logic [WIDTH-1:0] d;
        logic             ordy;
        logic             clr;
        logic             e_valid;
        logic [WIDTH-1:0] e_data;
        logic [1:0]       e_src;
        logic [3:0]       e_rdy;
        logic             e_esel;
        int               e_ecnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] s, input logic [3:0] v, input logic [WIDTH-1:0] d,
                       input logic ordy, input logic clr, input logic ev,
                       input logic [WIDTH-1:0] ed, input logic [1:0] es,
                       input logic [3:0] er, input logic eesel, input int ecnt);
        vec_t t;
        t.s = s; t.v = v; t.d = d; t.ordy = ordy; t.clr = clr;
        t.e_valid = ev; t.e_data = ed; t.e_src = es; t.e_rdy = er;
        t.e_esel = eesel; t.e_ecnt = ecnt;
        tbl.push_back(t);
    endtask

    task automatic model_reset();
        q.delete();
        m_last_data = '0;
        m_last_src  = '0;
        m_esel      = 1'b0;
        m_ecnt      = 0;
    endtask

    // Called just after a rising edge; drives one cycle and checks both sides of it.
    task automatic run_cycle(input logic [3:0] s, input logic [3:0] v, input logic [WIDTH-1:0] d,
                             input logic ordy, input logic clr);
        logic       legal;
        logic       multi;
        logic [1:0] idx;
        logic [3:0] exp_rdy;
        logic       acc;
        sel = s; in_valid = v; out_ready = ordy; err_clr = clr;
        for (int i = 0; i < INPUTS; i++) in_data[i] = s[i] ? d : WIDTH'($urandom);
        #1;
        legal = ($countones(s) == 1);
        multi = ($countones(s) > 1);
        idx = '0;
        for (int i = 0; i < INPUTS; i++) if (s[i]) idx = 2'(i);
        exp_rdy = (legal && q.size() < 2) ? s : 4'b0000;
        rdy_before = in_ready;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = legal && v[idx] && exp_rdy[idx];
        @(posedge clk);
        #1;
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (acc) q.push_back(beat_t'{data: d, src: idx});
        if (q.size() > 0) begin
            m_last_data = q[0].data;
            m_last_src  = q[0].src;
        end
        m_esel = multi;
        if (clr) m_ecnt = 0;
        else if (multi && m_ecnt < (1 << ERRW) - 1) m_ecnt++;
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("out_data", 32'(out_data), 32'(m_last_data));
        chk("out_src", 32'(out_src), 32'(m_last_src));
        chk("err_sel", 32'(err_sel), 32'(m_esel));
        chk("err_cnt", 32'(err_cnt), 32'(m_ecnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < INPUTS; i++) in_data[i] = '0;

        // Streaming, backpressure, sel switch, illegal select, saturation/clear.
        for (int k = 0; k < 8; k++)
            add(4'b0100, 4'b0100, WIDTH'(16'hA0 + k), 1, 0, 1, WIDTH'(16'hA0 + k), 2, 4'b0100, 0, 0);
        add(4'b0000, 4'b0000, 16'h0000, 1, 0, 0, 16'hA7, 2, 4'b0000, 0, 0);
        add(4'b0100, 4'b0100, 16'h00A0, 0, 0, 1, 16'hA0, 2, 4'b0100, 0, 0);
        add(4'b0100, 4'b0100, 16'h00A1, 0, 0, 1, 16'hA0, 2, 4'b0100, 0, 0);
        add(4'b0100, 4'b0100, 16'h00A2, 0, 0, 1, 16'hA0, 2, 4'b0000, 0, 0);
        add(4'b0100, 4'b0100, 16'h00A2, 1, 0, 1, 16'hA1, 2, 4'b0000, 0, 0);
        add(4'b0100, 4'b0100, 16'h00A2, 1, 0, 1, 16'hA2, 2, 4'b0100, 0, 0);
        add(4'b0000, 4'b0000, 16'h0000, 1, 0, 0, 16'hA2, 2, 4'b0000, 0, 0);
        add(4'b0001, 4'b0001, 16'h0011, 0, 0, 1, 16'h11, 0, 4'b0001, 0, 0);
        add(4'b1000, 4'b1000, 16'h0088, 0, 0, 1, 16'h11, 0, 4'b1000, 0, 0);
        add(4'b0000, 4'b0000, 16'h0000, 1, 0, 1, 16'h88, 3, 4'b0000, 0, 0);
        add(4'b0000, 4'b0000, 16'h0000, 1, 0, 0, 16'h88, 3, 4'b0000, 0, 0);
        for (int k = 0; k < 3; k++)
            add(4'b0110, 4'b1111, 16'h0000, 1, 0, 0, 16'h88, 3, 4'b0000, 1, k + 1);
        for (int k = 0; k < 5; k++)
            add(4'b0000, 4'b1111, 16'h0000, 1, 0, 0, 16'h88, 3, 4'b0000, 0, 3);
        for (int k = 0; k < 2; k++)
            add(4'b0110, 4'b1111, 16'h0000, 1, 0, 0, 16'h88, 3, 4'b0000, 1, 3);
        add(4'b0110, 4'b1111, 16'h0000, 1, 1, 0, 16'h88, 3, 4'b0000, 1, 0);
        add(4'b0000, 4'b0000, 16'h0000, 1, 0, 0, 16'h88, 3, 4'b0000, 0, 0);

        sel = 4'b0001; in_valid = 4'b0001;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        rst_n = 1'b1;
        model_reset();

        foreach (tbl[r]) begin
            run_cycle(tbl[r].s, tbl[r].v, tbl[r].d, tbl[r].ordy, tbl[r].clr);
            chk($sformatf("row%0d_rdy", r), 32'(rdy_before), 32'(tbl[r].e_rdy));
            chk($sformatf("row%0d_valid", r), 32'(out_valid), 32'(tbl[r].e_valid));
            chk($sformatf("row%0d_data", r), 32'(out_data), 32'(tbl[r].e_data));
            chk($sformatf("row%0d_src", r), 32'(out_src), 32'(tbl[r].e_src));
            chk($sformatf("row%0d_esel", r), 32'(err_sel), 32'(tbl[r].e_esel));
            chk($sformatf("row%0d_ecnt", r), 32'(err_cnt), 32'(tbl[r].e_ecnt));
        end

        // Reset with main and skid both holding beats and a nonzero error count.
        run_cycle(4'b0110, 4'b0000, 16'h0000, 1, 0);
        run_cycle(4'b0010, 4'b0010, 16'h005A, 0, 0);
        run_cycle(4'b0010, 4'b0010, 16'h005B, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_out_data", 32'(out_data), 32'h0);
        chk("mid_rst_out_src", 32'(out_src), 32'h0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'h0);
        chk("mid_rst_err_sel", 32'(err_sel), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cycle(4'b0010, 4'b0010, 16'h0077, 1, 0);
        chk("post_rst_data", 32'(out_data), 32'h77);
        run_cycle(4'b0000, 4'b0000, 16'h0000, 1, 0);
        chk("post_rst_skid_gone", 32'(out_valid), 32'h0);

        for (int n = 0; n < 500; n++) begin
            logic [3:0] s;
            int pick;
            pick = $urandom_range(0, 9);
            if (pick < 6)      s = 4'(1 << $urandom_range(0, 3));
            else if (pick < 8) s = 4'b0000;
            else               s = 4'($urandom);
            run_cycle(s, 4'($urandom), WIDTH'($urandom), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
